neighbor_table_writer: RTL
==========================

Name: neighbor_table_writer

Overview:
- Write-side counterpart of the next-hop selection logic. That logic only reads the shared node memory; this block fills it.
- On each received beacon, it looks up the sender in the neighborID table. It then creates or refreshes the sender's entry and writes the clusterID, batteryStat and qValue fields into the memory regions the policy block reads.
- It sits between the packet-receive path and the shared 16-bit memory port.

Parameters:
- MAX_NEIGHBORS, 64: neighbor table slots.
- NBR_ID_BASE, 16'h0048: neighborID region base.
- CLUSTER_BASE, 16'h00C8: clusterID region base.
- BATT_BASE, 16'h0148: batteryStat region base.
- QVAL_BASE, 16'h01C8: qValue region base.
- WORD_WIDTH, 16: data/address width.

Ports:
- clock  in  1  system clock, rising edge
- nreset  in  1  asynchronous active-low reset
- start  in  1  request, sampled in IDLE only
- my_node_id  in  16  own node ID
- rx_neighbor_id  in  16  beacon sender ID
- rx_cluster_id  in  16  sender cluster ID
- rx_battery  in  16  sender battery status
- rx_qvalue  in  16  sender advertised Q-value
- address  out  16  memory byte address
- wr_en  out  1  memory write strobe
- mem_data_in  out  16  memory write data
- mem_data_out  in  16  memory read data, valid one cycle after address
- slot_index  out  6  slot written or matched
- is_new  out  1  entry was newly created
- table_full  out  1  no free slot, nothing written
- rejected  out  1  invalid sender ID, nothing written
- neighbor_count  out  7  number of occupied slots, 0..64
- done  out  1  one-cycle completion pulse
- busy  out  1  high outside IDLE

Behaviour:
- Reset (asynchronous, nreset low): state IDLE. address, mem_data_in, slot_index and neighbor_count are 0. wr_en, done, busy, is_new, table_full and rejected are 0. Reset mid-operation abandons any partial write sequence; an entry may be left with only some fields updated.
- Table layout: slot k is at byte offset 2k in each region. Slot address = BASE + {k,1'b0}. The table is packed from slot 0 with no deletion. An ID of 16'h0000 marks an empty slot.
- IDLE: when start=1, latch all rx_* inputs, clear the status flags, and branch:
  - rx_neighbor_id==0 or rx_neighbor_id==my_node_id: go to DONE with rejected=1.
  - otherwise: set k=0 and go to SCAN_ADDR.
- SCAN_ADDR (1 cycle): address = NBR_ID_BASE+2k, wr_en=0. Go to SCAN_CHK.
- SCAN_CHK (1 cycle): compare mem_data_out.
  - equals latched ID: slot_index=k, is_new=0, go to WR_CLUSTER.
  - equals 0: slot_index=k, is_new=1, go to WR_ID.
  - otherwise, if k==MAX_NEIGHBORS-1: table_full=1, go to DONE.
  - otherwise: k=k+1, go to SCAN_ADDR.
- WR_ID: wr_en=1, address=NBR_ID_BASE+2k, data=ID. neighbor_count increments by 1.
- WR_CLUSTER, WR_BATT, WR_QVAL: one cycle each, wr_en=1 at the respective region address with the latched field. Then go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. Status outputs hold until the next accepted start.
- Latency from the start-sampled edge to the done cycle, match at slot k:
  - refresh of an existing entry: 2(k+1)+3+1 cycles.
  - new entry: 2(k+1)+4+1 cycles.
  - full table: 2·64+1 cycles.
  - rejected: 1 cycle.
- start while busy is ignored, not queued.
- Address arithmetic is 16-bit unsigned with no wrap checks; the parameters guarantee the regions are in range.
- wr_en is high only in the WR_* states. There is never more than one write per cycle.
- neighbor_count saturates at 64.

Decomposition:
- Shared package: memory map constants (region bases, slot stride 2, EMPTY_ID=0, MAX_NEIGHBORS) and the state encoding. The policy block uses the same map.
- One natural sub-module: nbr_slot_scanner. It holds the slot counter, address generation and the match/empty/full compare, and returns slot and result to the top FSM, which sequences the writes.

Test Plan:
- Reset, memory preloaded with zeros, start with id=4, cluster=2, batt=90, q=3 -> writes 4@0x48, 2@0xC8, 90@0x148, 3@0x1C8. slot_index=0, is_new=1, neighbor_count=1, done on cycle 7.
- Slots 0–2 hold IDs 7, 4, 9; start id=4, q=12 -> no ID write; 12@0x1CA; is_new=0, slot_index=1, neighbor_count unchanged, done 3+2·2+1 cycles later.
- Start with id=5 and my_node_id=5, then id=0 -> rejected=1, wr_en never asserted, done 1 cycle after start.
- All 64 slots nonzero with no match -> table_full=1, zero writes, done after 129 cycles.
- Start pulsed again while busy, then nreset pulsed low mid-WR_BATT -> second start ignored. After reset: outputs at reset values, wr_en low immediately, IDLE accepts a new start next cycle.

Source files
------------

// File: rtl/neighbor_table_writer_pkg.sv
// Memory map and state encoding shared by the neighbor table writer and the
// next-hop policy block that reads the same node memory.
package neighbor_table_writer_pkg;

  localparam int unsigned NTW_MAX_NEIGHBORS = 64;
  localparam int unsigned NTW_WORD_WIDTH    = 16;
  localparam int unsigned NTW_SLOT_W        = 6;
  localparam int unsigned NTW_COUNT_W       = 7;
  localparam int unsigned NTW_SLOT_STRIDE   = 2;

  localparam logic [15:0] NTW_NBR_ID_BASE  = 16'h0048;
  localparam logic [15:0] NTW_CLUSTER_BASE = 16'h00C8;
  localparam logic [15:0] NTW_BATT_BASE    = 16'h0148;
  localparam logic [15:0] NTW_QVAL_BASE    = 16'h01C8;

  // A neighborID of zero marks an unused slot.
  localparam logic [15:0] NTW_EMPTY_ID = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN_ADDR,
    ST_SCAN_CHK,
    ST_WR_ID,
    ST_WR_CLUSTER,
    ST_WR_BATT,
    ST_WR_QVAL,
    ST_DONE
  } ntw_state_e;

  // Byte offset of a slot inside any region (slots are 16-bit words).
  function automatic logic [NTW_SLOT_W:0] slot_offset(input logic [NTW_SLOT_W-1:0] slot);
    return (NTW_SLOT_W+1)'(slot) * (NTW_SLOT_W+1)'(NTW_SLOT_STRIDE);
  endfunction

endpackage

// File: rtl/neighbor_table_writer_nbr_slot_scanner.sv
// Walks the neighborID region slot by slot: owns the slot counter, produces
// the read address and classifies the returned word as match/empty/last.
module nbr_slot_scanner
  import neighbor_table_writer_pkg::*;
#(
  parameter int unsigned MAX_NEIGHBORS = NTW_MAX_NEIGHBORS,
  parameter int unsigned WORD_WIDTH    = NTW_WORD_WIDTH,
  parameter logic [15:0] NBR_ID_BASE   = NTW_NBR_ID_BASE
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  scan_clear,
  input  logic                  scan_step,
  input  logic [WORD_WIDTH-1:0] target_id,
  input  logic [WORD_WIDTH-1:0] mem_data_out,
  output logic [NTW_SLOT_W-1:0] scan_slot,
  output logic [WORD_WIDTH-1:0] scan_address,
  output logic                  hit_match,
  output logic                  hit_empty,
  output logic                  at_last
);

  // Slot counter: restarts at slot 0 for each accepted beacon.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      scan_slot <= '0;
    end else if (scan_clear) begin
      scan_slot <= '0;
    end else if (scan_step) begin
      scan_slot <= scan_slot + 1'b1;
    end
  end

  // Address of the current slot and classification of the word read back.
  always_comb begin
    scan_address = WORD_WIDTH'(NBR_ID_BASE) + WORD_WIDTH'(slot_offset(scan_slot));
    hit_match    = (mem_data_out == target_id);
    hit_empty    = (mem_data_out == WORD_WIDTH'(NTW_EMPTY_ID));
    at_last      = (scan_slot == NTW_SLOT_W'(MAX_NEIGHBORS - 1));
  end

endmodule

// File: rtl/neighbor_table_writer.sv
// Creates or refreshes a neighbor entry in shared node memory for each
// received beacon: scans the neighborID table, then writes the ID (new
// entries only), clusterID, batteryStat and qValue fields.
module neighbor_table_writer
  import neighbor_table_writer_pkg::*;
#(
  parameter int unsigned MAX_NEIGHBORS = NTW_MAX_NEIGHBORS,
  parameter logic [15:0] NBR_ID_BASE   = NTW_NBR_ID_BASE,
  parameter logic [15:0] CLUSTER_BASE  = NTW_CLUSTER_BASE,
  parameter logic [15:0] BATT_BASE     = NTW_BATT_BASE,
  parameter logic [15:0] QVAL_BASE     = NTW_QVAL_BASE,
  parameter int unsigned WORD_WIDTH    = NTW_WORD_WIDTH
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic                   start,
  input  logic [WORD_WIDTH-1:0]  my_node_id,
  input  logic [WORD_WIDTH-1:0]  rx_neighbor_id,
  input  logic [WORD_WIDTH-1:0]  rx_cluster_id,
  input  logic [WORD_WIDTH-1:0]  rx_battery,
  input  logic [WORD_WIDTH-1:0]  rx_qvalue,
  output logic [WORD_WIDTH-1:0]  address,
  output logic                   wr_en,
  output logic [WORD_WIDTH-1:0]  mem_data_in,
  input  logic [WORD_WIDTH-1:0]  mem_data_out,
  output logic [NTW_SLOT_W-1:0]  slot_index,
  output logic                   is_new,
  output logic                   table_full,
  output logic                   rejected,
  output logic [NTW_COUNT_W-1:0] neighbor_count,
  output logic                   done,
  output logic                   busy
);

  ntw_state_e state, state_nx;

  logic [WORD_WIDTH-1:0] id_q, cluster_q, batt_q, qval_q;
  logic                  sender_invalid;
  logic                  scan_clear, scan_step;
  logic                  hit_match, hit_empty, at_last;
  logic [NTW_SLOT_W-1:0] scan_slot;
  logic [WORD_WIDTH-1:0] scan_address;
  logic [WORD_WIDTH-1:0] slot_byte_off;

  nbr_slot_scanner #(
    .MAX_NEIGHBORS (MAX_NEIGHBORS),
    .WORD_WIDTH    (WORD_WIDTH),
    .NBR_ID_BASE   (NBR_ID_BASE)
  ) u_scanner (
    .clock        (clock),
    .nreset       (nreset),
    .scan_clear   (scan_clear),
    .scan_step    (scan_step),
    .target_id    (id_q),
    .mem_data_out (mem_data_out),
    .scan_slot    (scan_slot),
    .scan_address (scan_address),
    .hit_match    (hit_match),
    .hit_empty    (hit_empty),
    .at_last      (at_last)
  );

  // Beacons from ourselves or with the reserved empty ID are never stored.
  always_comb begin
    sender_invalid = (rx_neighbor_id == WORD_WIDTH'(NTW_EMPTY_ID)) ||
                     (rx_neighbor_id == my_node_id);
    slot_byte_off  = WORD_WIDTH'(slot_offset(slot_index));
  end

  // State register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and memory-port drive; writes only happen in WR_* states.
  always_comb begin
    state_nx    = state;
    address     = '0;
    wr_en       = 1'b0;
    mem_data_in = '0;
    scan_clear  = 1'b0;
    scan_step   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          scan_clear = 1'b1;
          state_nx   = sender_invalid ? ST_DONE : ST_SCAN_ADDR;
        end
      end
      ST_SCAN_ADDR: begin
        address  = scan_address;
        state_nx = ST_SCAN_CHK;
      end
      ST_SCAN_CHK: begin
        address = scan_address;
        if (hit_match) begin
          state_nx = ST_WR_CLUSTER;
        end else if (hit_empty) begin
          state_nx = ST_WR_ID;
        end else if (at_last) begin
          state_nx = ST_DONE;
        end else begin
          scan_step = 1'b1;
          state_nx  = ST_SCAN_ADDR;
        end
      end
      ST_WR_ID: begin
        wr_en       = 1'b1;
        address     = scan_address;
        mem_data_in = id_q;
        state_nx    = ST_WR_CLUSTER;
      end
      ST_WR_CLUSTER: begin
        wr_en       = 1'b1;
        address     = WORD_WIDTH'(CLUSTER_BASE) + slot_byte_off;
        mem_data_in = cluster_q;
        state_nx    = ST_WR_BATT;
      end
      ST_WR_BATT: begin
        wr_en       = 1'b1;
        address     = WORD_WIDTH'(BATT_BASE) + slot_byte_off;
        mem_data_in = batt_q;
        state_nx    = ST_WR_QVAL;
      end
      ST_WR_QVAL: begin
        wr_en       = 1'b1;
        address     = WORD_WIDTH'(QVAL_BASE) + slot_byte_off;
        mem_data_in = qval_q;
        state_nx    = ST_DONE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    done = (state == ST_DONE);
    busy = (state != ST_IDLE);
  end

  // Beacon latch, status flags and occupancy count.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      id_q           <= '0;
      cluster_q      <= '0;
      batt_q         <= '0;
      qval_q         <= '0;
      slot_index     <= '0;
      is_new         <= 1'b0;
      table_full     <= 1'b0;
      rejected       <= 1'b0;
      neighbor_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            id_q       <= rx_neighbor_id;
            cluster_q  <= rx_cluster_id;
            batt_q     <= rx_battery;
            qval_q     <= rx_qvalue;
            slot_index <= '0;
            is_new     <= 1'b0;
            table_full <= 1'b0;
            rejected   <= sender_invalid;
          end
        end
        ST_SCAN_CHK: begin
          if (hit_match) begin
            slot_index <= scan_slot;
            is_new     <= 1'b0;
          end else if (hit_empty) begin
            slot_index <= scan_slot;
            is_new     <= 1'b1;
          end else if (at_last) begin
            table_full <= 1'b1;
          end
        end
        ST_WR_ID: begin
          if (neighbor_count < NTW_COUNT_W'(MAX_NEIGHBORS)) begin
            neighbor_count <= neighbor_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
